// File: rtl/ec_frame_assembler.sv
// ----------------------------------------------------------------------------
// ec_frame_assembler
//
// Packs a stream of WIDTH-bit measurement words into N-word frames and hands
// each finished frame, flattened to WIDTH*N bits, to the column-XOR parity
// stage. Two banks are used ping-pong style so that streaming continues while
// a finished frame waits for the downstream stage.
//
// Optional feature (compile-time macro EC_FRAME_SYNDROME_REG_EN):
//   adds per-bank running column-XOR accumulators and a syndrome output that
//   equals the column XOR of the presented frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      incoming word
//   in_valid     in_data valid
//   in_ready     a word can be accepted this cycle (registered state only)
//   flush        discard the partially filled frame (synchronous)
//   frame        flattened frame, word k at frame[k*WIDTH +: WIDTH]; 0 if idle
//   frame_valid  frame holds a complete frame
//   frame_ready  downstream consumes the frame
//   word_count   words held in the partially filled bank
//   syndrome     column XOR of frame (macro build only)
// ----------------------------------------------------------------------------
module ec_frame_assembler #(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 flush,
   output logic [WIDTH*N-1:0]   frame,
   output logic                 frame_valid,
   input  logic                 frame_ready,
   output logic [CNT_W-1:0]     word_count
`ifdef EC_FRAME_SYNDROME_REG_EN
   ,
   output logic [WIDTH-1:0]     syndrome
`endif
);

   logic [WIDTH*N-1:0] bank_q [2];
   logic [1:0]         full_q;
   logic               fill_ptr_q;
   logic               rd_ptr_q;
   logic [CNT_W-1:0]   idx_q;

   logic accept;
   logic last_word;
   logic consume;

   assign in_ready    = !full_q[fill_ptr_q];
   assign frame_valid = full_q[rd_ptr_q];
   assign frame       = frame_valid ? bank_q[rd_ptr_q] : '0;
   assign word_count  = idx_q;

   // flush has priority: a word presented together with flush is dropped
   assign accept    = in_valid && in_ready && !flush;
   assign last_word = (idx_q == CNT_W'(N - 1));
   assign consume   = frame_valid && frame_ready;

   // Completion always targets the fill bank and consume the rd bank. They can
   // only coincide on the same bank if it were both empty and full, so the two
   // bit updates of full_q never collide.
   // NOTE: every register below uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q     <= '0;
         fill_ptr_q <= 1'b0;
         rd_ptr_q   <= 1'b0;
         idx_q      <= '0;
      end else begin
         if (flush) begin
            idx_q <= '0;
         end else if (accept) begin
            if (last_word) begin
               full_q[fill_ptr_q] <= 1'b1;
               fill_ptr_q         <= ~fill_ptr_q;
               idx_q              <= '0;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
         if (consume) begin
            full_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q         <= ~rd_ptr_q;
         end
      end
   end

   // NOTE: bank storage is not reset; frame is forced to zero unless the rd
   // bank is marked full, so stale contents can never reach the output.
   always_ff @(posedge clk) begin
      if (accept) begin
         bank_q[fill_ptr_q][int'(idx_q)*WIDTH +: WIDTH] <= in_data;
      end
   end

`ifdef EC_FRAME_SYNDROME_REG_EN
   logic [WIDTH-1:0] acc_q [2];

   // The first word of a frame overwrites the accumulator, which clears it
   // at frame start. A flush only clears the fill bank while it is still
   // partial; a full fill bank holds a pending frame's syndrome.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q[0] <= '0;
         acc_q[1] <= '0;
      end else if (flush) begin
         if (!full_q[fill_ptr_q]) begin
            acc_q[fill_ptr_q] <= '0;
         end
      end else if (accept) begin
         acc_q[fill_ptr_q] <= (idx_q == '0) ? in_data : (acc_q[fill_ptr_q] ^ in_data);
      end
   end

   assign syndrome = frame_valid ? acc_q[rd_ptr_q] : '0;
`endif

endmodule

// File: doc/ec_frame_assembler.md
Name: ec_frame_assembler

Overview:
- Collects a stream of WIDTH-bit measurement words into N-word frames.
- Presents each complete frame as a flattened WIDTH*N bus, directly upstream of the column-XOR parity stage.
- Double-buffered (two banks, ping-pong), so input streaming continues while a completed frame waits for the downstream stage.
- Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8: bits per word, i.e. number of parity columns.
- N, 4: words per frame, i.e. rows XORed per column. Must be >= 1.
- CNT_W, $clog2(N+1): localparam; width of word_count.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  incoming word
- in_valid  input  1  in_data valid
- in_ready  output  1  assembler can accept a word this cycle
- flush  input  1  synchronous discard of the partially filled frame
- frame  output  WIDTH*N  flattened frame; word k at frame[k*WIDTH +: WIDTH]
- frame_valid  output  1  frame holds a complete frame
- frame_ready  input  1  downstream consumes frame
- word_count  output  CNT_W  words held in the partially filled bank
- syndrome  output  WIDTH  only with SYNDROME_REG_EN (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - both banks empty; fill pointer = rd pointer = bank 0; write index = 0.
  - Outputs: in_ready=1, frame_valid=0, frame=0, word_count=0, syndrome=0.
  - Applies immediately, mid-frame included; partial and complete frames are lost.
- Packing:
  - k-th accepted word of a frame (k = 0..N-1) is stored at bits [k*WIDTH +: WIDTH].
  - So bit j of word k is frame[k*WIDTH+j], giving column j = XOR over k of frame[k*WIDTH+j].
- Accept: in_valid && in_ready on a rising edge.
  - in_ready = fill bank not full; purely from registered state, no combinational path from in_valid or frame_ready.
  - Accept with write index < N-1: write word, index++, word_count++.
  - Accept with write index = N-1: write word, mark bank full, index=0, word_count=0, toggle fill pointer.
  - in_ready drops the cycle after a completion only if the new fill bank is still full, i.e. both banks full.
- Output:
  - frame_valid = rd bank full.
  - frame = rd bank contents when frame_valid=1; all zeros otherwise.
  - frame must hold stable while frame_valid && !frame_ready.
  - On frame_valid && frame_ready: rd bank marked empty, rd pointer toggles. The next full bank, if any, is presented the following cycle.
  - Back-to-back frames with frame_ready held high: one frame per N input cycles, no bubbles.
- Latency: last word accepted at edge t -> frame_valid=1 after edge t (visible cycle t+1), provided the rd bank was that bank.
- Simultaneous events:
  - Completion on the fill bank and consume on the other bank in the same cycle: both take effect; in_ready stays 1.
  - Consume of a bank in the same cycle it becomes the fill bank: it is empty next cycle; no data corruption.
- flush:
  - Resets write index and word_count to 0.
  - Full banks are untouched.
  - flush plus accept in the same cycle: flush wins and the word is dropped.
  - flush with word_count=0: no effect.
- N=1: every accepted word completes a frame; word_count is always 0.

Optional Feature:
- Macro: EC_FRAME_SYNDROME_REG_EN.
- Defined:
  - Adds a registered syndrome output with running column-XOR accumulators per bank. Each bank's accumulator is cleared at frame start and XORed with each accepted word.
  - syndrome = accumulator of the rd bank when frame_valid=1, 0 otherwise.
  - Valid in the same cycle as frame_valid and equal to the column XOR of frame.
  - flush also clears the fill bank accumulator.
- Undefined: syndrome port and accumulators absent; all other behaviour identical.

Test Plan:
- WIDTH=8, N=4, frame_ready=1; send 0x01,0x02,0x04,0x80 -> one cycle after 4th accept: frame_valid=1, frame=0x80040201, word_count=0; with macro, syndrome=0x87.
- frame_ready=0; send 8 words 0x11..0x18 -> after 8th accept in_ready=0, frame=0x14131211 held stable; 9th word not accepted. Raise frame_ready one cycle -> frame=0x18171615 next cycle, in_ready=1.
- Send 0xAA,0xBB, assert flush with in_valid=1 and in_data=0xCC, then send 0x01..0x04 -> word_count goes 1,2,0; frame=0x04030201; 0xCC absent.
- Continuous in_valid=1, frame_ready=1, 12 words -> 3 frames, frame_valid pulses every 4th cycle, in_ready never drops.
- Reset asserted mid-frame after 2 words and with one full bank pending -> frame_valid=0, frame=0, word_count=0, in_ready=1 immediately; after release, first 4 words form a fresh frame.
- N=1, WIDTH=8: words 0x5A,0xA5 with frame_ready=1 -> frame_valid high two consecutive cycles, frame=0x5A then 0xA5.
